// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall indices, stall vectors, FSM state encodings and reset polarity.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int MC_CNT_W_DEF = 6;
    localparam int PC_W_DEF     = 32;

    // Stall vector bit positions, one per pipeline register.
    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef logic [STALL_W-1:0] stall_t;

    // A stall from stage N holds PC and every register up to and including N.
    localparam stall_t STALL_VEC_NONE = 6'b000000;
    localparam stall_t STALL_VEC_ID   = 6'b000111;
    localparam stall_t STALL_VEC_EX   = 6'b001111;
    localparam stall_t STALL_VEC_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'd0,
        CTRL_MC_BUSY = 2'd1,
        CTRL_FLUSH   = 2'd2
    } ctrl_state_e;

    // Reset is asserted when rst equals this value.
    localparam logic RST_ACTIVE = 1'b0;

    // Strict-priority stall selection: flush > MEM > EX multi-cycle > ID.
    function automatic stall_t stall_sel(input logic flush_act, input logic mem_req,
                                         input logic ex_req, input logic id_req);
        stall_t s;
        if (flush_act)    s = STALL_VEC_NONE;
        else if (mem_req) s = STALL_VEC_MEM;
        else if (ex_req)  s = STALL_VEC_EX;
        else if (id_req)  s = STALL_VEC_ID;
        else              s = STALL_VEC_NONE;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/stall bundle between the pipeline stages and pipe_ctrl.
// Latency: n/a (wires only). master = pipeline side, slave = pipe_ctrl side.
// Backpressure: stall is the backpressure; PIPE_CTRL_PERF_EN adds perf counter outputs.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = MC_CNT_W_DEF,
    parameter int PC_W     = PC_W_DEF
) ();

    // Requests from the pipeline
    logic                stallreq_id;
    logic                stallreq_mem;
    logic                ex_mc_start;
    logic [MC_CNT_W-1:0] ex_mc_cycles;
    logic                flush_req;
    logic [PC_W-1:0]     flush_pc;

    // Controls back to the pipeline
    stall_t              stall;
    logic                flush;
    logic [PC_W-1:0]     new_pc;
    logic                ex_mc_done;
    logic                mc_busy;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]         perf_stall_cnt;
    logic [15:0]         perf_flush_cnt;

    modport master (
        output stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        input  stall, flush, new_pc, ex_mc_done, mc_busy, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        output stall, flush, new_pc, ex_mc_done, mc_busy, perf_stall_cnt, perf_flush_cnt
    );
`else
    modport master (
        output stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        input  stall, flush, new_pc, ex_mc_done, mc_busy
    );

    modport slave (
        input  stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles, flush_req, flush_pc,
        output stall, flush, new_pc, ex_mc_done, mc_busy
    );
`endif

endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// pipe_ctrl_mc_counter: loadable down-counter with enable, sync clear and zero/one detect.
// Latency: 1 cycle from clr/load/en to count; flags are combinational from the count.
// Backpressure: en low freezes the count; never wraps below zero.
// Ports: clk, rst (async active-low), clr_i > load_i > en_i, load_val_i, zero_o, one_o.
module pipe_ctrl_mc_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = MC_CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush scheduler for the 5-stage pipeline, sequences EX multi-cycle ops.
// Latency: stall is combinational (0 cycles); flush/new_pc/ex_mc_done are registered (1 cycle).
// Backpressure: MEM stall freezes the multi-cycle counter; flush_req overrides everything.
// Ports: clk, rst (async active-low), bus (pipe_ctrl_if.slave).
// Optional: define PIPE_CTRL_PERF_EN to add saturating perf_stall_cnt / perf_flush_cnt outputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = MC_CNT_W_DEF,
    parameter int PC_W     = PC_W_DEF
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);

    ctrl_state_e     state_q, state_d;
    logic [PC_W-1:0] new_pc_q, new_pc_d;
    logic            done_q, done_d;

    logic                cnt_clr;
    logic                cnt_load;
    logic                cnt_en;
    logic [MC_CNT_W-1:0] cnt_load_val;
    logic                cnt_zero;
    logic                cnt_one;
    logic                mc_long;
    stall_t              stall_s;

    // Ops of 0 or 1 cycles finish without stalling; the rest stall EX for cycles-1.
    assign mc_long      = (bus.ex_mc_cycles > MC_CNT_W'(1));
    assign cnt_load_val = bus.ex_mc_cycles - MC_CNT_W'(1);

    pipe_ctrl_mc_counter #(
        .W (MC_CNT_W)
    ) u_mc_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    always_comb begin
        state_d  = state_q;
        new_pc_d = '0;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        if (bus.flush_req) begin
            // Flush beats everything: aborts any op and discards a same-cycle start.
            state_d  = CTRL_FLUSH;
            new_pc_d = bus.flush_pc;
            cnt_clr  = 1'b1;
        end else begin
            unique case (state_q)
                CTRL_IDLE: begin
                    if (bus.ex_mc_start) begin
                        if (mc_long) begin
                            state_d  = CTRL_MC_BUSY;
                            cnt_load = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                CTRL_MC_BUSY: begin
                    // Starts here are ignored: EX is held and cannot legally issue.
                    if (!bus.stallreq_mem) begin
                        // Zero cannot occur while busy; treating it as completion keeps
                        // the FSM from ever hanging in MC_BUSY.
                        if (cnt_one || cnt_zero) begin
                            state_d = CTRL_IDLE;
                            done_d  = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                CTRL_FLUSH: begin
                    state_d = CTRL_IDLE;
                end
                default: begin
                    state_d = CTRL_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q  <= CTRL_IDLE;
            new_pc_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
            done_q   <= done_d;
        end
    end

    // Gated by reset so the vector reads zero while reset is asserted, whatever the inputs.
    always_comb begin
        stall_s = STALL_VEC_NONE;
        if (rst != RST_ACTIVE) begin
            stall_s = stall_sel(state_q == CTRL_FLUSH, bus.stallreq_mem,
                                state_q == CTRL_MC_BUSY, bus.stallreq_id);
        end
    end

    assign bus.stall      = stall_s;
    assign bus.flush      = (state_q == CTRL_FLUSH);
    assign bus.new_pc     = new_pc_q;
    assign bus.ex_mc_done = done_q;
    assign bus.mc_busy    = (state_q == CTRL_MC_BUSY);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if ((stall_s != STALL_VEC_NONE) && !(&perf_stall_q)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if ((state_q == CTRL_FLUSH) && !(&perf_flush_q)) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized bench for pipe_ctrl against a cycle-level reference model.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Define PIPE_CTRL_PERF_EN at compile time to also check the perf counters.
module tb_pipe_ctrl;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.MC_CNT_W(6), .PC_W(32)) bus ();

    pipe_ctrl #(.MC_CNT_W(6), .PC_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Reference model: outputs expected for the current cycle.
    bit          m_busy;
    bit          m_flush;
    bit          m_done;
    int          m_left;     // non-MEM-stalled busy cycles still owed by the running op
    logic [31:0] m_pc;
    longint      m_scnt;
    longint      m_fcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_flush = 0;
        m_done  = 0;
        m_left  = 0;
        m_pc    = '0;
        m_scnt  = 0;
        m_fcnt  = 0;
    endtask

    // One cycle: drive, compare against the model, then advance the model.
    task automatic step(input bit id, input bit mem, input bit start, input int cyc,
                        input bit freq, input logic [31:0] fpc);
        logic [5:0] exp_stall;
        @(negedge clk);
        bus.stallreq_id  = id;
        bus.stallreq_mem = mem;
        bus.ex_mc_start  = start;
        bus.ex_mc_cycles = 6'(cyc);
        bus.flush_req    = freq;
        bus.flush_pc     = fpc;
        #1;
        if (m_flush)     exp_stall = 6'b000000;
        else if (mem)    exp_stall = 6'b011111;
        else if (m_busy) exp_stall = 6'b001111;
        else if (id)     exp_stall = 6'b000111;
        else             exp_stall = 6'b000000;
        chk("stall", 32'(bus.stall), 32'(exp_stall));
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("ex_mc_done", 32'(bus.ex_mc_done), 32'(m_done));
        chk("mc_busy", 32'(bus.mc_busy), 32'(m_busy));
        if (m_flush) chk("new_pc", bus.new_pc, m_pc);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cnt", bus.perf_stall_cnt, 32'(m_scnt));
        chk("perf_flush_cnt", 32'(bus.perf_flush_cnt), 32'(m_fcnt));
`endif
        if (exp_stall != 0 && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        if (m_flush && m_fcnt < 64'hFFFF) m_fcnt++;
        if (freq) begin
            m_flush = 1;
            m_pc    = fpc;
            m_busy  = 0;
            m_done  = 0;
            m_left  = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (!mem) m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (!m_flush && start) begin
                if (cyc >= 2) begin
                    m_busy = 1;
                    m_left = cyc - 1;
                end else begin
                    m_done = 1;
                end
            end
            m_flush = 0;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst              = 1'b0;
        bus.stallreq_id  = 1'b1;
        bus.stallreq_mem = 1'b0;
        bus.ex_mc_start  = 1'b0;
        bus.ex_mc_cycles = '0;
        bus.flush_req    = 1'b0;
        bus.flush_pc     = '0;

        // Reset state, with a stall request present to show reset masks it.
        #3;
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_new_pc", bus.new_pc, 32'h0);
        chk("rst_done", 32'(bus.ex_mc_done), 32'h0);
        chk("rst_busy", 32'(bus.mc_busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.stallreq_id = 1'b0;
        rst = 1'b1;

        // Load-use stall for exactly two cycles.
        step(1, 0, 0, 0, 0, 32'h0);
        chk("id_stall_1", 32'(bus.stall), 32'h07);
        step(1, 0, 0, 0, 0, 32'h0);
        chk("id_stall_2", 32'(bus.stall), 32'h07);
        idle();
        chk("id_stall_end", 32'(bus.stall), 32'h00);

        // Four-cycle op: three EX stall cycles, done on the fourth.
        step(0, 0, 1, 4, 0, 32'h0);
        chk("mc4_start_stall", 32'(bus.stall), 32'h00);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("mc4_stall", 32'(bus.stall), 32'h0F);
            chk("mc4_done_early", 32'(bus.ex_mc_done), 32'h0);
        end
        idle();
        chk("mc4_done", 32'(bus.ex_mc_done), 32'h1);
        chk("mc4_busy_fall", 32'(bus.mc_busy), 32'h0);

        // Short ops: done next cycle with no stall.
        step(0, 0, 1, 1, 0, 32'h0);
        idle();
        chk("mc1_done", 32'(bus.ex_mc_done), 32'h1);
        step(0, 0, 1, 0, 0, 32'h0);
        idle();
        chk("mc0_done", 32'(bus.ex_mc_done), 32'h1);

        // MEM wait in the middle of a four-cycle op delays done by two.
        step(0, 0, 1, 4, 0, 32'h0);
        idle();
        step(0, 1, 0, 0, 0, 32'h0);
        chk("mc_mem_stall", 32'(bus.stall), 32'h1F);
        step(0, 1, 0, 0, 0, 32'h0);
        idle();
        chk("mc_mem_resume", 32'(bus.stall), 32'h0F);
        idle();
        chk("mc_mem_not_yet", 32'(bus.ex_mc_done), 32'h0);
        idle();
        chk("mc_mem_done", 32'(bus.ex_mc_done), 32'h1);

        // Flush during an op, together with a MEM stall.
        step(0, 0, 1, 8, 0, 32'h0);
        idle();
        step(0, 1, 0, 0, 1, 32'hBFC0_0380);
        step(0, 1, 0, 0, 0, 32'h0);
        chk("flush_pulse", 32'(bus.flush), 32'h1);
        chk("flush_pc", bus.new_pc, 32'hBFC0_0380);
        chk("flush_stall", 32'(bus.stall), 32'h00);
        for (int i = 0; i < 8; i++) begin
            idle();
            chk("flush_no_done", 32'(bus.ex_mc_done), 32'h0);
        end

        // Start together with flush is discarded.
        step(0, 0, 1, 5, 1, 32'h1234_5678);
        idle();
        idle();
        chk("start_flush_busy", 32'(bus.mc_busy), 32'h0);

        // Asynchronous reset in the middle of an op.
        step(0, 0, 1, 10, 0, 32'h0);
        idle();
        bus.stallreq_id = 1'b1;
        rst = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall), 32'h0);
        chk("arst_busy", 32'(bus.mc_busy), 32'h0);
        chk("arst_done", 32'(bus.ex_mc_done), 32'h0);
        chk("arst_flush", 32'(bus.flush), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.stallreq_id = 1'b0;
        rst = 1'b1;
        model_reset();
        idle();
        chk("arst_release_stall", 32'(bus.stall), 32'h0);
        for (int i = 0; i < 12; i++) idle();

        // Three flushes then five stalled cycles (counters start from reset).
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 32'h8000_0000 + 32'(i));
            idle();
        end
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 32'h0);
        idle();
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_flush_3", 32'(bus.perf_flush_cnt), 32'd3);
        chk("perf_stall_5", bus.perf_stall_cnt, 32'd5);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit id_r, mem_r, st_r, fl_r;
            int cyc_r;
            id_r  = ($urandom_range(0, 99) < 25);
            mem_r = ($urandom_range(0, 99) < 20);
            st_r  = ($urandom_range(0, 99) < 15);
            fl_r  = ($urandom_range(0, 99) < 4);
            cyc_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                : int'($urandom_range(0, 9));
            step(id_r, mem_r, st_r, cyc_r, fl_r, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
